// File: rtl/phys_free_list_pkg.sv
// Shared rename-stage definitions: register-file sizes, zero register and free-list FSM states.
package phys_free_list_pkg;

    localparam int unsigned PHYS_REG_SZ     = 64;
    localparam int unsigned REG_SZ          = 32;
    localparam int unsigned PHYS_REG_IDX_SZ = $clog2(PHYS_REG_SZ);
    localparam int unsigned ZERO_REG        = 0;

    typedef enum logic [1:0] {
        FL_INIT,
        FL_READY,
        FL_RECOVER
    } FL_STATE;

endpackage

// File: rtl/phys_free_list.sv
// Physical-register free list: circular buffer with speculative head, retired head and tail,
// self-initialised after reset and rolled back to the retired head on a mispredict.
module phys_free_list #(
    parameter int unsigned PHYS_REG_SZ = phys_free_list_pkg::PHYS_REG_SZ,
    parameter int unsigned ARCH_REG_SZ = phys_free_list_pkg::REG_SZ,
    parameter int unsigned LIST_SZ     = PHYS_REG_SZ - ARCH_REG_SZ,
    localparam int unsigned PR_W       = $clog2(PHYS_REG_SZ) + 1,
    localparam int unsigned IDX_W      = $clog2(LIST_SZ),
    localparam int unsigned PTR_W      = IDX_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             alloc_req,
    output logic             alloc_gnt,
    output logic [PR_W-1:0]  alloc_pr,
    input  logic             retire_enable,
    input  logic [PR_W-1:0]  retire_old_pr,
    input  logic             recover_enable,
    output logic             fl_ready,
    output logic [PTR_W-1:0] free_count,
    output logic             fl_error
);

    import phys_free_list_pkg::*;

    FL_STATE          state_q;
    logic [IDX_W-1:0] init_cnt_q;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W-1:0] commit_head_q;
    logic [PTR_W-1:0] commit_head_d;
    logic [PR_W-1:0]  entries_q [LIST_SZ];
    logic             fl_error_q;

    logic [PTR_W-1:0] count;
    logic             empty;
    logic             full;
    logic             ready;
    logic             retire_ok;
    logic             retire_wr;

    // LIST_SZ is a power of two, so plain overflow wraps the index and toggles the wrap bit.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return ptr + PTR_W'(1);
    endfunction

    always_comb begin
        count         = tail_q - head_q;
        empty         = (count == '0);
        full          = (count == PTR_W'(LIST_SZ));
        ready         = (state_q == FL_READY);
        alloc_gnt     = alloc_req & ready & ~empty & ~recover_enable;
        alloc_pr      = ready ? entries_q[head_q[IDX_W-1:0]] : '0;
        retire_ok     = retire_enable & (state_q != FL_INIT) & ~full;
        retire_wr     = retire_ok & (retire_old_pr != PR_W'(ZERO_REG));
        commit_head_d = retire_ok ? ptr_inc(commit_head_q) : commit_head_q;
    end

    assign free_count = count;
    assign fl_ready   = ready;
    assign fl_error   = fl_error_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= FL_INIT;
            init_cnt_q    <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            commit_head_q <= '0;
            fl_error_q    <= 1'b0;
        end else begin
            unique case (state_q)
                FL_INIT: begin
                    init_cnt_q <= init_cnt_q + IDX_W'(1);
                    if (retire_enable || recover_enable) begin
                        fl_error_q <= 1'b1;
                    end
                    if (init_cnt_q == IDX_W'(LIST_SZ - 1)) begin
                        head_q        <= '0;
                        commit_head_q <= '0;
                        tail_q        <= PTR_W'(LIST_SZ);
                        state_q       <= FL_READY;
                    end
                end
                FL_READY, FL_RECOVER: begin
                    commit_head_q <= commit_head_d;
                    if (retire_wr) begin
                        tail_q <= ptr_inc(tail_q);
                    end
                    if (retire_enable && full) begin
                        fl_error_q <= 1'b1;
                    end
                    // Rollback uses the retired head including this cycle's retire.
                    if (recover_enable) begin
                        head_q  <= commit_head_d;
                        state_q <= FL_RECOVER;
                    end else begin
                        if (alloc_gnt) begin
                            head_q <= ptr_inc(head_q);
                        end
                        state_q <= FL_READY;
                    end
                end
                default: state_q <= FL_INIT;
            endcase
        end
    end

    // Storage is deliberately not reset; INIT rewrites every slot before first use.
    always_ff @(posedge clk) begin
        if (state_q == FL_INIT) begin
            entries_q[init_cnt_q] <= PR_W'(ARCH_REG_SZ) + PR_W'(init_cnt_q);
        end else if (retire_wr) begin
            entries_q[tail_q[IDX_W-1:0]] <= retire_old_pr;
        end
    end

endmodule

// File: tb/tb_phys_free_list.sv
// Free-list bench: directed scenarios with literal expectations plus randomized traffic,
// all checked every cycle against an unbounded-log model of the list.
module tb_phys_free_list;

    localparam int unsigned ARCH = 32;
    localparam int unsigned LIST = 32;

    logic       clk;
    logic       reset_n;
    logic       alloc_req;
    logic       alloc_gnt;
    logic [6:0] alloc_pr;
    logic       retire_enable;
    logic [6:0] retire_old_pr;
    logic       recover_enable;
    logic       fl_ready;
    logic [5:0] free_count;
    logic       fl_error;

    phys_free_list dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .alloc_req      (alloc_req),
        .alloc_gnt      (alloc_gnt),
        .alloc_pr       (alloc_pr),
        .retire_enable  (retire_enable),
        .retire_old_pr  (retire_old_pr),
        .recover_enable (recover_enable),
        .fl_ready       (fl_ready),
        .free_count     (free_count),
        .fl_error       (fl_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: absolute (never wrapping) positions into an unbounded log of registers.
    int unsigned mem [int];
    int m_head, m_tail, m_commit;
    int m_state;  // 0 init, 1 ready, 2 recover
    int m_init_cyc;
    bit m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        mem.delete();
        for (int i = 0; i < LIST; i++) mem[i] = ARCH + i;
        m_head = 0; m_tail = 0; m_commit = 0;
        m_state = 0; m_init_cyc = 0; m_err = 0;
    endtask

    always @(negedge clk) begin
        int cnt;
        bit rdy, gnt;
        if (!reset_n) begin
            chk("rst_gnt", alloc_gnt, 0);
            chk("rst_pr", alloc_pr, 0);
            chk("rst_ready", fl_ready, 0);
            chk("rst_count", free_count, 0);
            chk("rst_err", fl_error, 0);
            model_reset();
        end else begin
            rdy = (m_state == 1);
            cnt = m_tail - m_head;
            gnt = alloc_req && rdy && (cnt > 0) && !recover_enable;
            chk("m_ready", fl_ready, rdy);
            chk("m_count", free_count, cnt);
            chk("m_gnt", alloc_gnt, gnt);
            chk("m_err", fl_error, m_err);
            if (rdy && cnt > 0) chk("m_pr", alloc_pr, mem[m_head]);
            else if (!rdy) chk("m_pr_zero", alloc_pr, 0);
            if (m_state == 0) begin
                if (retire_enable || recover_enable) m_err = 1;
                m_init_cyc++;
                if (m_init_cyc == LIST) begin
                    m_tail  = LIST;
                    m_state = 1;
                end
            end else begin
                if (retire_enable) begin
                    if (cnt == LIST) m_err = 1;
                    else begin
                        m_commit++;
                        if (retire_old_pr != 0) begin
                            mem[m_tail] = retire_old_pr;
                            m_tail++;
                        end
                    end
                end
                if (recover_enable) begin
                    m_head  = m_commit;
                    m_state = 2;
                end else begin
                    if (gnt) m_head++;
                    m_state = 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit a, input bit r, input logic [6:0] pr, input bit rec);
        alloc_req      = a;
        retire_enable  = r;
        retire_old_pr  = pr;
        recover_enable = rec;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(0, 0, 7'd0, 0);
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic wait_init();
        repeat (LIST) step();
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 7'd0, 0);

        // Init timing and first grant
        do_reset();
        repeat (LIST - 1) step();
        #1 chk("ready_cycle31", fl_ready, 0);
        step();
        #1;
        chk("ready_cycle32", fl_ready, 1);
        chk("init_count", free_count, 32);
        chk("first_pr", alloc_pr, 32);

        // Drain the whole list, then one more request
        for (int i = 0; i < 33; i++) begin
            drive(1, 0, 7'd0, 0);
            #1;
            if (i < 32) begin
                chk("drain_gnt", alloc_gnt, 1);
                chk("drain_pr", alloc_pr, 32 + i);
            end else begin
                chk("empty_gnt", alloc_gnt, 0);
                chk("empty_count", free_count, 0);
            end
            step();
        end
        drive(0, 0, 7'd0, 0);

        // Grant 5, retire 2 (old reg 7), recover
        do_reset();
        wait_init();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 7'd0, 0);
            #1 chk("g5_pr", alloc_pr, 32 + i);
            step();
        end
        drive(0, 1, 7'd7, 0); step();
        drive(0, 1, 7'd7, 0); step();
        drive(1, 0, 7'd0, 1);
        #1 chk("recover_cycle_gnt", alloc_gnt, 0);
        step();
        drive(1, 0, 7'd0, 0);
        #1;
        chk("recover_state_gnt", alloc_gnt, 0);
        chk("recover_state_ready", fl_ready, 0);
        chk("recover_state_count", free_count, 32);
        step();
        #1;
        chk("post_recover_gnt", alloc_gnt, 1);
        chk("post_recover_pr", alloc_pr, 34);
        step();
        drive(0, 0, 7'd0, 0);
        #1 chk("post_recover_count", free_count, 31);

        // Same-cycle grant and retire of register 9
        drive(1, 1, 7'd9, 0);
        #1;
        chk("same_gnt", alloc_gnt, 1);
        chk("same_pr", alloc_pr, 35);
        step();
        drive(0, 0, 7'd0, 0);
        #1 chk("same_count", free_count, 31);
        for (int i = 0; i < 31; i++) begin
            drive(1, 0, 7'd0, 0);
            #1;
            chk("walk_gnt", alloc_gnt, 1);
            chk("walk_pr", alloc_pr, (i < 28) ? 36 + i : ((i < 30) ? 7 : 9));
            step();
        end
        drive(0, 0, 7'd0, 0);
        #1 chk("walk_count", free_count, 0);

        // Zero-register retire: tail holds, retired head still advances
        drive(0, 1, 7'd0, 0); step();
        drive(0, 0, 7'd0, 0);
        #1 chk("zero_ret_count", free_count, 0);
        drive(0, 0, 7'd0, 1); step();
        drive(0, 0, 7'd0, 0); step();
        #1;
        chk("zero_ret_recover_count", free_count, 31);
        chk("zero_ret_err", fl_error, 0);

        // Retire during INIT
        do_reset();
        repeat (3) step();
        drive(0, 1, 7'd5, 0); step();
        drive(0, 0, 7'd0, 0);
        #1 chk("init_ret_err", fl_error, 1);
        repeat (40) step();
        #1;
        chk("init_ret_err_sticky", fl_error, 1);
        chk("init_ret_count", free_count, 32);

        // Retire while full, then asynchronous reset clears the flag
        do_reset();
        wait_init();
        #1 chk("full_err_before", fl_error, 0);
        drive(0, 1, 7'd5, 0); step();
        drive(0, 0, 7'd0, 0);
        #1;
        chk("full_ret_err", fl_error, 1);
        chk("full_ret_count", free_count, 32);
        repeat (5) step();
        #1 chk("full_err_sticky", fl_error, 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_err", fl_error, 0);
        chk("async_rst_ready", fl_ready, 0);
        chk("async_rst_count", free_count, 0);

        // Randomized traffic with legal retires only
        for (int round = 0; round < 4; round++) begin
            do_reset();
            wait_init();
            for (int c = 0; c < 600; c++) begin
                bit a, r, rec;
                logic [6:0] pr;
                a   = ($urandom_range(0, 9) < 6);
                r   = (m_state != 0) && (m_head - m_commit > 0) && ($urandom_range(0, 9) < 4);
                pr  = ($urandom_range(0, 32) == 0) ? 7'd0 : 7'($urandom_range(1, 63));
                rec = ($urandom_range(0, 39) == 0);
                drive(a, r, pr, rec);
                step();
            end
            drive(0, 0, 7'd0, 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
